// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request/response bundle between the datapath control and the
// sequential multiply/divide unit.
//   start, op, A, B        : request (driven by the master)
//   busy, done, result,
//   div_by_zero, zero      : response (driven by the unit)
interface mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 op;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 div_by_zero;
    logic                 zero;

    modport master (
        output start, op, A, B,
        input  busy, done, result, div_by_zero, zero
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, result, div_by_zero, zero
    );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative signed multiply / divide, one bit per clock.
//   clock       : rising-edge clock
//   clear       : asynchronous active-low reset
//   bus (slave) : start/op/A/B request; busy/done/result/div_by_zero/zero response
// Multiply is radix-2 Booth over {P, Q, q-1}; divide is restoring on operand
// magnitudes with a final sign-fix step. result packs the product, or
// {remainder, quotient}. All response signals are registered except zero.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clock,
    input  logic        clear,
    mdu_seq_if.slave    bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 dbz_q, dbz_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_q, op_d;
    // hi carries one guard bit: Booth's P +/- M can exceed WIDTH signed bits
    // (e.g. 0 - 0x80000000), and the restoring shift needs WIDTH+1 bits.
    logic [WIDTH:0]       hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 q1_q, q1_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;

    // Booth / restoring intermediates
    logic [WIDTH:0]       booth_p_s;
    logic [WIDTH:0]       div_shift_s;
    logic [WIDTH:0]       div_m_s;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.op && (bus.B == {WIDTH{1'b0}})) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the current state; registered below, so they
    // trail the state by one cycle (busy and done can then never overlap).
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            S_IDLE:  begin busy_d = 1'b0; done_d = 1'b0; end
            S_RUN:   begin busy_d = 1'b1; done_d = 1'b0; end
            S_FIX:   begin busy_d = 1'b1; done_d = 1'b0; end
            S_DONE:  begin busy_d = 1'b0; done_d = 1'b1; end
            default: begin busy_d = 1'b0; done_d = 1'b0; end
        endcase
    end

    // Single iteration of Booth add/sub and restoring trial subtraction
    always_comb begin
        case ({lo_q[0], q1_q})
            2'b01:   booth_p_s = hi_q + {m_q[WIDTH-1], m_q};
            2'b10:   booth_p_s = hi_q - {m_q[WIDTH-1], m_q};
            default: booth_p_s = hi_q;
        endcase
        div_shift_s = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_m_s     = {1'b0, m_q};
    end

    // Datapath next-state: operand capture, iteration, sign fix, result write
    always_comb begin
        result_d  = result_q;
        dbz_d     = dbz_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        q1_d      = q1_q;
        m_d       = m_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    cnt_d = {CNT_W{1'b0}};
                    hi_d  = {(WIDTH+1){1'b0}};
                    q1_d  = 1'b0;
                    dbz_d = bus.op && (bus.B == {WIDTH{1'b0}});
                    if (bus.op) begin
                        lo_d      = abs_val(bus.A);
                        m_d       = abs_val(bus.B);
                        neg_quo_d = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        neg_rem_d = bus.A[WIDTH-1];
                        // Divide by zero skips RUN; this edge enters DONE.
                        if (bus.B == {WIDTH{1'b0}}) begin
                            result_d = {bus.A, {WIDTH{1'b1}}};
                        end else begin
                            result_d = result_q;
                        end
                    end else begin
                        lo_d      = bus.A;
                        m_d       = bus.B;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q) begin
                    if (div_shift_s >= div_m_s) begin
                        hi_d = div_shift_s - div_m_s;
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift_s;
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // Arithmetic right shift of {P, Q, q-1} after the add/sub.
                    hi_d = {booth_p_s[WIDTH], booth_p_s[WIDTH:1]};
                    lo_d = {booth_p_s[0], lo_q[WIDTH-1:1]};
                    q1_d = lo_q[0];
                end
            end
            S_FIX: begin
                if (op_q) begin
                    result_d = {cond_neg(hi_q[WIDTH-1:0], neg_rem_q),
                                cond_neg(lo_q, neg_quo_q)};
                end else begin
                    result_d = {hi_q[WIDTH-1:0], lo_q};
                end
            end
            S_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= {(2*WIDTH){1'b0}};
            dbz_q     <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            op_q      <= 1'b0;
            hi_q      <= {(WIDTH+1){1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            q1_q      <= 1'b0;
            m_q       <= {WIDTH{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            q1_q      <= q1_d;
            m_q       <= m_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.zero        = (result_q == {(2*WIDTH){1'b0}});

endmodule
